// File: rtl/kbd_arb_pkg.sv
// Shared types and constants for the Apple 1 keyboard input arbiter.
// Holds the state and mode encodings and the byte translation helper.
package kbd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } kbd_state_e;

    localparam logic [1:0] MODE_BOTH = 2'b00;
    localparam logic [1:0] MODE_UART = 2'b01;
    localparam logic [1:0] MODE_PS2  = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic SRC_UART = 1'b0;
    localparam logic SRC_PS2  = 1'b1;

    // Line-end codes pass untouched; lower-case letters fold to upper case when enabled.
    function automatic logic [7:0] kbd_translate(input logic [7:0] c, input logic upper_en);
        logic [7:0] r;
        r = c;
        case (c)
            ASCII_CR, ASCII_LF: r = c;
            default: begin
                if (upper_en && (c >= 8'h61) && (c <= 8'h7A)) begin
                    r = c - 8'h20;
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/kbd_input_arbiter_if.sv
// Bundle of the source handshakes, CPU read strobe and keyboard register outputs.
// The arbiter uses the slave view; whatever drives the sources and CPU uses master.
interface kbd_input_arbiter_if;
    logic [1:0] src_mode;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       uart_ready;
    logic       uart_cts;
    logic       ps2_strobe;
    logic [7:0] ps2_data;
    logic       ps2_overflow;
    logic       cpu_rd;
    logic       key_ready;
    logic [7:0] key_data;

    modport slave (
        input  src_mode, uart_valid, uart_data, ps2_strobe, ps2_data, cpu_rd,
        output uart_ready, uart_cts, ps2_overflow, key_ready, key_data
    );

    modport master (
        output src_mode, uart_valid, uart_data, ps2_strobe, ps2_data, cpu_rd,
        input  uart_ready, uart_cts, ps2_overflow, key_ready, key_data
    );
endinterface

// File: rtl/kbd_fifo.sv
// Small synchronous FIFO with registered full/empty flags and an occupancy count.
// Head data is read combinationally so a pop and its data land on the same edge.
module kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/kbd_input_arbiter.sv
// Merges UART and PS/2 key bytes into the Apple 1 KBD/KBDCR register.
// Each source is buffered; a round-robin FSM presents one key until the CPU reads it.
module kbd_input_arbiter
    import kbd_arb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int UPPERCASE_EN = 1,
    parameter int LF_DROP      = 1,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                 clk25,
    input  logic                 rst,
    kbd_input_arbiter_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    // GAP state lasts one cycle less than the low time: the IDLE load edge closes the gap.
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_HOLD = 2'(HOLD);
    localparam logic [1:0] ST_GAP  = 2'(GAP);

    logic [7:0]    uart_char;
    logic [7:0]    ps2_char;
    logic          uart_is_lf;
    logic          ps2_is_lf;
    logic          uart_ready;
    logic          uart_push;
    logic          ps2_push;
    logic          ovf_d;

    logic          uart_pop;
    logic          ps2_pop;
    logic [7:0]    uart_rdata;
    logic [7:0]    ps2_rdata;
    logic          uart_full;
    logic          ps2_full;
    logic          uart_empty;
    logic          ps2_empty;
    logic [CW-1:0] uart_count;
    logic [CW-1:0] ps2_count_unused;

    logic          uart_en;
    logic          ps2_en;
    logic          uart_cand;
    logic          ps2_cand;
    logic          grant_ps2;
    logic [7:0]    grant_data;

    logic [1:0]    state_q, state_d;
    logic          rr_q, rr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          key_ready_q, key_ready_d;
    logic [7:0]    key_data_q, key_data_d;
    logic          ovf_q;

    // Write-side translation happens before the FIFO so stored bytes are final.
    assign uart_char  = kbd_translate(bus.uart_data, UPPERCASE_EN != 0);
    assign ps2_char   = kbd_translate(bus.ps2_data, UPPERCASE_EN != 0);
    assign uart_is_lf = (LF_DROP != 0) && (bus.uart_data == ASCII_LF);
    assign ps2_is_lf  = (LF_DROP != 0) && (bus.ps2_data == ASCII_LF);

    assign uart_ready = !rst && !uart_full;
    assign uart_push  = bus.uart_valid && uart_ready && !uart_is_lf;
    assign ps2_push   = bus.ps2_strobe && !ps2_full && !ps2_is_lf;
    assign ovf_d      = bus.ps2_strobe && ps2_full && !ps2_is_lf;

    kbd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_uart_fifo (
        .clk     (clk25),
        .rst     (rst),
        .push_i  (uart_push),
        .wdata_i (uart_char),
        .pop_i   (uart_pop),
        .rdata_o (uart_rdata),
        .full_o  (uart_full),
        .empty_o (uart_empty),
        .count_o (uart_count)
    );

    kbd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_ps2_fifo (
        .clk     (clk25),
        .rst     (rst),
        .push_i  (ps2_push),
        .wdata_i (ps2_char),
        .pop_i   (ps2_pop),
        .rdata_o (ps2_rdata),
        .full_o  (ps2_full),
        .empty_o (ps2_empty),
        .count_o (ps2_count_unused)
    );

    always_comb begin
        uart_en = 1'b0;
        ps2_en  = 1'b0;
        case (bus.src_mode)
            MODE_BOTH: begin
                uart_en = 1'b1;
                ps2_en  = 1'b1;
            end
            MODE_UART: uart_en = 1'b1;
            MODE_PS2:  ps2_en  = 1'b1;
            MODE_NONE: ;
        endcase
    end

    assign uart_cand = uart_en && !uart_empty;
    assign ps2_cand  = ps2_en && !ps2_empty;
    // With both candidates, the source other than the last winner gets the grant.
    assign grant_ps2  = (uart_cand && ps2_cand) ? (rr_q == SRC_UART) : ps2_cand;
    assign grant_data = grant_ps2 ? ps2_rdata : uart_rdata;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gap_d       = gap_q;
        key_ready_d = key_ready_q;
        key_data_d  = key_data_q;
        uart_pop    = 1'b0;
        ps2_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (uart_cand || ps2_cand) begin
                    uart_pop    = !grant_ps2;
                    ps2_pop     = grant_ps2;
                    key_data_d  = grant_data | 8'h80;
                    key_ready_d = 1'b1;
                    rr_d        = grant_ps2 ? SRC_PS2 : SRC_UART;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.cpu_rd) begin
                    key_ready_d = 1'b0;
                    gap_d       = GAP_LOAD;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= SRC_UART;
            gap_q       <= '0;
            key_ready_q <= 1'b0;
            key_data_q  <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gap_q       <= gap_d;
            key_ready_q <= key_ready_d;
            key_data_q  <= key_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.uart_ready   = uart_ready;
    assign bus.uart_cts     = !rst && (uart_count <= CW'(FIFO_DEPTH - 2));
    assign bus.ps2_overflow = ovf_q;
    assign bus.key_ready    = key_ready_q;
    assign bus.key_data     = key_data_q;

endmodule
